// File: rtl/data_mem_lsu.sv
// data_mem_lsu -- MEM-stage load/store responder with a private data RAM.
//
// Takes the decoder's memory controls plus the EX-stage address/store data,
// performs byte-enabled little-endian stores and sign/zero-extended loads
// against a 64-bit-wide RAM, and issues one response pulse per request.
// An access whose bytes cross a doubleword boundary is split into two beats,
// and ready drops for the second one.
//
// Optional feature macro: DLSU_MISALIGN_TRAP_EN
//   When it is defined, any access with addr mod size != 0 is answered at once
//   with misaligned=1. It does not touch the RAM.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   mem_read/mem_write  request (store wins when both are set)
//   mem_sign            1 = zero-extend, 0 = sign-extend
//   mem_width           0=B 1=H 2=W 3=D
//   addr, wdata         byte address, store data (low bytes used)
//   ready               request accepted this cycle
//   rsp_valid           one-cycle response pulse
//   rdata               extended load data (0 for stores/faults)
//   access_fault        response touched a byte outside the RAM
//   misaligned          (DLSU_MISALIGN_TRAP_EN only) response was a misalign trap
`timescale 1ns/1ps

// One byte column of the data RAM: async read, synchronous write.
module dlsu_byte_bank #(
  parameter int DEPTH = 512,
  parameter int IDXW  = 9
) (
  input  logic            clk,
  input  logic            we,
  input  logic [IDXW-1:0] idx,
  input  logic [7:0]      wbyte,
  output logic [7:0]      rbyte
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wbyte;

  assign rbyte = mem[idx];
endmodule

module data_mem_lsu #(
  parameter int REG_WIDTH    = 64,
  parameter int DEPTH_DWORDS = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic                 mem_sign,
  input  logic [1:0]           mem_width,
  input  logic [REG_WIDTH-1:0] addr,
  input  logic [REG_WIDTH-1:0] wdata,
  output logic                 ready,
  output logic                 rsp_valid,
  output logic [REG_WIDTH-1:0] rdata,
  output logic                 access_fault
`ifdef DLSU_MISALIGN_TRAP_EN
  ,
  output logic                 misaligned
`endif
);
  localparam int          IDXW  = $clog2(DEPTH_DWORDS);
  localparam logic [64:0] LIMIT = 65'(DEPTH_DWORDS) << 3;

  // The first beat's request is held here while the second beat runs.
  typedef struct packed {
    logic            is_store;
    logic            sign;
    logic [1:0]      width;
    logic [2:0]      off;
    logic [IDXW-1:0] idx;
    logic [63:0]     wdata;
  } req_t;

  typedef enum logic {IDLE, BEAT2} state_t;

  state_t state, state_d;
  req_t   req_q;
  logic [63:0] lo_q;

  logic        beat;
  logic        req_in, fault_in, cross_in, mis_in, accept_ok;
  logic [3:0]  size_in, cur_size;
  logic [64:0] end_addr;

  logic [2:0]  cur_off;
  logic [1:0]  cur_width;
  logic        cur_sign;
  logic [63:0] cur_wdata;

  logic [IDXW-1:0] rd_idx;
  logic [63:0]     rd_data, lo, hi, ld_raw, ld_ext;
  logic [127:0]    wsh;
  logic [15:0]     bmask;
  logic            do_wr;
  logic [7:0]      lane_we;
  logic [7:0][7:0] lane_wb;

  logic        rsp_d, fault_d;
  logic [63:0] rdata_d;

  assign beat     = (state == BEAT2);
  assign ready    = ~beat;
  assign req_in   = mem_read | mem_write;
  assign size_in  = 4'd1 << mem_width;
  // The 65-bit end address catches both the out-of-range high bits and a
  // carry out of the top of the address space.
  assign end_addr = {1'b0, addr} + 65'(size_in);
  assign fault_in = end_addr > LIMIT;
  assign cross_in = ({1'b0, addr[2:0]} + size_in) > 4'd8;
`ifdef DLSU_MISALIGN_TRAP_EN
  // For sizes 1/2/4/8, size-1 truncated to 3 bits is the alignment mask.
  assign mis_in   = (addr[2:0] & (size_in[2:0] - 3'd1)) != 3'd0;
`else
  assign mis_in   = 1'b0;
`endif
  assign accept_ok = ~beat & req_in & ~fault_in & ~mis_in;

  // In BEAT2 the held request drives the datapath, and the inputs are ignored.
  assign cur_off   = beat ? req_q.off   : addr[2:0];
  assign cur_width = beat ? req_q.width : mem_width;
  assign cur_sign  = beat ? req_q.sign  : mem_sign;
  assign cur_wdata = beat ? req_q.wdata : wdata;
  assign cur_size  = 4'd1 << cur_width;
  assign rd_idx    = beat ? req_q.idx + IDXW'(1) : addr[3 +: IDXW];

  // Access bytes laid out over two consecutive dwords. The low half belongs
  // to beat 0, and the high half belongs to beat 1.
  assign wsh   = {64'b0, cur_wdata} << {cur_off, 3'b000};
  assign bmask = ((16'd1 << cur_size) - 16'd1) << cur_off;
  assign do_wr = beat ? req_q.is_store : (accept_ok & mem_write);

  for (genvar j = 0; j < 8; j++) begin : g_lane
    assign lane_we[j] = do_wr & (beat ? bmask[8+j] : bmask[j]);
    assign lane_wb[j] = beat ? wsh[64+8*j +: 8] : wsh[8*j +: 8];

    dlsu_byte_bank #(.DEPTH(DEPTH_DWORDS), .IDXW(IDXW)) u_bank (
      .clk   (clk),
      .we    (lane_we[j]),
      .idx   (rd_idx),
      .wbyte (lane_wb[j]),
      .rbyte (rd_data[8*j +: 8])
    );
  end

  assign lo     = beat ? lo_q    : rd_data;
  assign hi     = beat ? rd_data : 64'b0;
  assign ld_raw = 64'({hi, lo} >> {cur_off, 3'b000});

  always_comb begin
    ld_ext = ld_raw;
    case (cur_width)
      2'd0:    ld_ext = {{56{ld_raw[7]  & ~cur_sign}}, ld_raw[7:0]};
      2'd1:    ld_ext = {{48{ld_raw[15] & ~cur_sign}}, ld_raw[15:0]};
      2'd2:    ld_ext = {{32{ld_raw[31] & ~cur_sign}}, ld_raw[31:0]};
      default: ld_ext = ld_raw;
    endcase
  end

  // Next-state and response logic
  always_comb begin
    state_d = state;
    rsp_d   = 1'b0;
    fault_d = 1'b0;
    rdata_d = 64'b0;
    unique case (state)
      IDLE: if (req_in) begin
        if (fault_in) begin
          rsp_d   = 1'b1;
          fault_d = 1'b1;
        end else if (mis_in) begin
          rsp_d   = 1'b1;
        end else if (cross_in) begin
          state_d = BEAT2;
        end else begin
          rsp_d   = 1'b1;
          rdata_d = mem_write ? 64'b0 : ld_ext;
        end
      end
      BEAT2: begin
        state_d = IDLE;
        rsp_d   = 1'b1;
        rdata_d = req_q.is_store ? 64'b0 : ld_ext;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rsp_valid    <= 1'b0;
      rdata        <= '0;
      access_fault <= 1'b0;
      req_q        <= '0;
      lo_q         <= '0;
    end else begin
      state        <= state_d;
      rsp_valid    <= rsp_d;
      rdata        <= rdata_d;
      access_fault <= fault_d;
      if (!beat && state_d == BEAT2) begin
        req_q <= '{is_store: mem_write, sign: mem_sign, width: mem_width,
                   off: addr[2:0], idx: addr[3 +: IDXW], wdata: wdata};
        lo_q  <= rd_data;
      end
    end
  end

`ifdef DLSU_MISALIGN_TRAP_EN
  // The access fault takes priority over the misalign flag.
  always_ff @(posedge clk or posedge rst)
    if (rst) misaligned <= 1'b0;
    else     misaligned <= ~beat & req_in & ~fault_in & mis_in;
`endif
endmodule

// File: tb/tb_data_mem_lsu.sv
`timescale 1ns/1ps
module tb_data_mem_lsu;
  logic        clk = 1'b0, rst = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0, mem_sign = 1'b0;
  logic [1:0]  mem_width = 2'd0;
  logic [63:0] addr = '0, wdata = '0;
  logic        ready, rsp_valid, access_fault, misaligned;
  logic [63:0] rdata;

  always #5 clk = ~clk;

  data_mem_lsu #(.REG_WIDTH(64), .DEPTH_DWORDS(512)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_sign(mem_sign), .mem_width(mem_width), .addr(addr), .wdata(wdata),
    .ready(ready), .rsp_valid(rsp_valid), .rdata(rdata),
    .access_fault(access_fault)
`ifdef DLSU_MISALIGN_TRAP_EN
    , .misaligned(misaligned)
`endif
  );
`ifndef DLSU_MISALIGN_TRAP_EN
  assign misaligned = 1'b0;
`endif

  typedef struct {
    logic        rd, wr, sgn;
    logic [1:0]  w;
    logic [63:0] a, d, exp;
    logic        flt, mis, split;
  } vec_t;

  typedef struct {
    logic [63:0] exp;
    logic        flt, mis;
    int          cyc, id;
  } sb_t;

  sb_t  q[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;
  vec_t tv[22];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every rsp_valid.
  sb_t e;
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 want 0 at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        chk($sformatf("rsp%0d_rdata", e.id), rdata, e.exp);
        chk($sformatf("rsp%0d_fault", e.id), 64'(access_fault), 64'(e.flt));
        chk($sformatf("rsp%0d_misaligned", e.id), 64'(misaligned), 64'(e.mis));
        chk($sformatf("rsp%0d_cycle", e.id), 64'(cyc), 64'(e.cyc));
      end
    end
  end

  function automatic vec_t mk(logic rd, logic wr, logic sgn, logic [1:0] w,
                              logic [63:0] a, logic [63:0] d, logic [63:0] exp,
                              logic flt, logic split);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sgn = sgn; v.w = w; v.a = a; v.d = d;
    v.exp = exp; v.flt = flt; v.mis = 1'b0; v.split = split;
    return v;
  endfunction

  // With the misalign trap, a non-faulting misaligned access becomes a
  // one-cycle trap response.
  function automatic vec_t adj(vec_t v);
    vec_t       r;
    logic [2:0] m, lo3;
    r   = v;
    m   = 3'((4'd1 << v.w) - 4'd1);
    lo3 = v.a[2:0];
`ifdef DLSU_MISALIGN_TRAP_EN
    if (!v.flt && (lo3 & m) != 3'd0) begin
      r.exp = '0; r.mis = 1'b1; r.split = 1'b0;
    end
`else
    if (lo3 == m && m == 3'd7) r = v;  // keeps m/lo3 referenced in both builds
`endif
    return r;
  endfunction

  task automatic issue(input vec_t v, input int id, input bit push);
    sb_t s;
    int  n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout%0d: got ready=0 want 1", id);
    end
    mem_read = v.rd; mem_write = v.wr; mem_sign = v.sgn; mem_width = v.w;
    addr = v.a; wdata = v.d;
    if (push) begin
      s.exp = v.exp; s.flt = v.flt; s.mis = v.mis; s.id = id;
      s.cyc = cyc + 1 + (v.split ? 1 : 0);
      q.push_back(s);
    end
    if (v.split) begin
      @(negedge clk);
      chk($sformatf("ready_low%0d", id), 64'(ready), 64'd0);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rdata", rdata, 64'd0);
    chk("reset_fault", 64'(access_fault), 64'd0);
    chk("reset_misaligned", 64'(misaligned), 64'd0);
    rst = 1'b0;

    //          rd wr sg  w   addr                    wdata                  expected               flt split
    tv[0]  = mk(0, 1, 0, 3, 64'h10,                 64'h1122334455667788, 64'h0,                 0, 0);
    tv[1]  = mk(1, 0, 0, 3, 64'h10,                 64'h0,                64'h1122334455667788, 0, 0);
    tv[2]  = mk(1, 0, 0, 0, 64'h10,                 64'h0,                64'hFFFFFFFFFFFFFF88, 0, 0);
    tv[3]  = mk(1, 0, 1, 0, 64'h10,                 64'h0,                64'h88,               0, 0);
    tv[4]  = mk(1, 0, 0, 1, 64'h16,                 64'h0,                64'h1122,             0, 0);
    tv[5]  = mk(1, 0, 1, 2, 64'h14,                 64'h0,                64'h11223344,         0, 0);
    tv[6]  = mk(0, 1, 0, 3, 64'h18,                 64'hAABBCCDDEEFF0011, 64'h0,                 0, 0);
    tv[7]  = mk(1, 0, 0, 2, 64'h16,                 64'h0,                64'h00111122,         0, 1);
    tv[8]  = mk(0, 1, 0, 2, 64'h20,                 64'h80000000,         64'h0,                 0, 0);
    tv[9]  = mk(1, 0, 0, 2, 64'h20,                 64'h0,                64'hFFFFFFFF80000000, 0, 0);
    tv[10] = mk(1, 0, 1, 2, 64'h20,                 64'h0,                64'h80000000,         0, 0);
    tv[11] = mk(1, 1, 0, 2, 64'h20,                 64'h12345678,         64'h0,                 0, 0);
    tv[12] = mk(1, 0, 1, 2, 64'h20,                 64'h0,                64'h12345678,         0, 0);
    tv[13] = mk(1, 0, 0, 3, 64'h1000,               64'h0,                64'h0,                 1, 0);
    tv[14] = mk(0, 1, 0, 3, 64'hFF8,                64'h0123456789ABCDEF, 64'h0,                 0, 0);
    tv[15] = mk(0, 1, 0, 3, 64'hFFC,                64'hDEADBEEFDEADBEEF, 64'h0,                 1, 0);
    tv[16] = mk(1, 0, 0, 3, 64'hFF8,                64'h0,                64'h0123456789ABCDEF, 0, 0);
    tv[17] = mk(1, 0, 1, 1, 64'hFFF,                64'h0,                64'h0,                 1, 0);
    tv[18] = mk(1, 0, 0, 3, 64'h0000000100000010,   64'h0,                64'h0,                 1, 0);
    tv[19] = mk(1, 0, 1, 1, 64'h11,                 64'h0,                64'h6677,             0, 0);
    tv[20] = mk(1, 0, 0, 1, 64'h1A,                 64'h0,                64'hFFFFFFFFFFFFEEFF, 0, 0);
    tv[21] = mk(1, 0, 0, 0, 64'h18,                 64'h0,                64'h11,               0, 0);

    for (int i = 0; i < 22; i++) issue(adj(tv[i]), i, 1'b1);
    idle();

`ifndef DLSU_MISALIGN_TRAP_EN
    // Complete split store, then read both halves back
    issue(mk(0, 1, 0, 3, 64'h1C, 64'h8877665544332211, 64'h0, 0, 1), 30, 1'b1);
    issue(mk(1, 0, 1, 2, 64'h1C, 64'h0, 64'h44332211, 0, 0), 31, 1'b1);
    issue(mk(1, 0, 1, 2, 64'h20, 64'h0, 64'h88776655, 0, 0), 32, 1'b1);
    issue(mk(1, 0, 1, 0, 64'h23, 64'h0, 64'h88, 0, 0), 33, 1'b1);
    idle();
    repeat (3) @(negedge clk);

    // Reset during BEAT2: only the beat-0 bytes land, and there is no response
    issue(mk(0, 1, 0, 3, 64'h1C, 64'hA1A2A3A4B1B2B3B4, 64'h0, 0, 1), 40, 1'b0);
    rst = 1'b1; mem_write = 1'b0; mem_read = 1'b0;
    #1;
    chk("rst_beat2_ready", 64'(ready), 64'd1);
    chk("rst_beat2_rsp", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk("rst_beat2_rsp_hold", 64'(rsp_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rsp", 64'(rsp_valid), 64'd0);
    issue(mk(1, 0, 1, 2, 64'h1C, 64'h0, 64'hB1B2B3B4, 0, 0), 41, 1'b1);
    issue(mk(1, 0, 1, 2, 64'h20, 64'h0, 64'h88776655, 0, 0), 42, 1'b1);
`else
    // A misaligned load and a misaligned store trap and leave the RAM as it was
    begin
      vec_t v;
      v = mk(1, 0, 0, 1, 64'h11, 64'h0, 64'h0, 0, 0); v.mis = 1'b1;
      issue(v, 50, 1'b1);
      v = mk(0, 1, 0, 1, 64'h11, 64'hBEEF, 64'h0, 0, 0); v.mis = 1'b1;
      issue(v, 51, 1'b1);
      issue(mk(1, 0, 1, 0, 64'h11, 64'h0, 64'h77, 0, 0), 52, 1'b1);
      issue(mk(1, 0, 1, 0, 64'h12, 64'h0, 64'h66, 0, 0), 53, 1'b1);
    end
`endif
    idle();
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
